// File: rtl/seven_segment_capture.sv
// Receive side of the two-digit multiplexed seven-segment bus: settles, captures and decodes each digit phase.
// Optional raw-pattern outputs are enabled by defining SEV_SEG_CAPTURE_RAW_EN.
module seven_segment_capture #(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [6:0] i_sev_segments,
    input  logic       i_sev_seg_cathode,
    output logic [7:0] o_value,
    output logic       o_frame_valid,
    output logic       o_decode_err,
    output logic       o_stale
`ifdef SEV_SEG_CAPTURE_RAW_EN
    ,
    output logic [6:0] o_raw_digit_0,
    output logic [6:0] o_raw_digit_1
`endif
);

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned IN_W   = SEG_W + 1;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned STAB_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_HOLD   = 1'b1
    } state_t;

    // Lit pattern (g..a) to {error, nibble}; unknown glyphs decode to 0 with error set.
    function automatic logic [NIB_W:0] decode_glyph(input logic [SEG_W-1:0] lit);
        logic [NIB_W:0] res;
        res = {1'b1, NIB_W'(0)};
        case (lit)
            7'h3F: res = 5'h00;
            7'h06: res = 5'h01;
            7'h5B: res = 5'h02;
            7'h4F: res = 5'h03;
            7'h66: res = 5'h04;
            7'h6D: res = 5'h05;
            7'h7D: res = 5'h06;
            7'h07: res = 5'h07;
            7'h7F: res = 5'h08;
            7'h6F: res = 5'h09;
            7'h77: res = 5'h0A;
            7'h7C: res = 5'h0B;
            7'h39: res = 5'h0C;
            7'h5E: res = 5'h0D;
            7'h79: res = 5'h0E;
            7'h71: res = 5'h0F;
            default: res = {1'b1, NIB_W'(0)};
        endcase
        return res;
    endfunction

    logic [IN_W-1:0]   r_sync1;
    logic [IN_W-1:0]   r_sync2;
    logic [IN_W-1:0]   r_prev;
    logic [STAB_W-1:0] r_stab_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    state_t            r_state;
    logic              r_have_d0;
    logic [NIB_W-1:0]  r_d0;
    logic              r_err0;
    logic [7:0]        r_value;
    logic              r_frame_valid;
    logic              r_decode_err;
    logic              r_stale;

    logic [SEG_W-1:0]  w_seg;
    logic              w_changed;
    logic              w_cath_toggle;
    logic              w_capture;
    logic              w_digit1;
    logic [NIB_W:0]    w_dec;
    logic [TO_W-1:0]   w_to_next;

    assign w_seg         = SEG_ACTIVE_LOW ? ~r_sync2[SEG_W-1:0] : r_sync2[SEG_W-1:0];
    assign w_changed     = (r_sync2 != r_prev);
    assign w_cath_toggle = (r_sync2[IN_W-1] != r_prev[IN_W-1]);
    assign w_digit1      = r_sync2[IN_W-1];
    assign w_dec         = decode_glyph(w_seg);
    // Capture only on a cycle that itself is stable, so a same-cycle toggle is never lost.
    assign w_capture     = (r_state == ST_SETTLE) && (r_stab_cnt == STAB_W'(SETTLE_CYCLES)) && !w_changed;
    assign w_to_next     = w_cath_toggle ? TO_W'(0)
                         : (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) ? r_to_cnt
                         : r_to_cnt + TO_W'(1);

    // Input synchroniser, stability and timeout counters.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_stab_cnt <= '0;
            r_to_cnt   <= '0;
            r_stale    <= 1'b0;
        end else begin
            r_sync1  <= {i_sev_seg_cathode, i_sev_segments};
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_to_cnt <= w_to_next;
            r_stale  <= (w_to_next == TO_W'(TIMEOUT_CYCLES));
            if (w_changed) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != STAB_W'(SETTLE_CYCLES)) begin
                r_stab_cnt <= r_stab_cnt + STAB_W'(1);
            end
        end
    end

    // Phase FSM and frame assembly.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state       <= ST_SETTLE;
            r_have_d0     <= 1'b0;
            r_d0          <= '0;
            r_err0        <= 1'b0;
            r_value       <= '0;
            r_frame_valid <= 1'b0;
            r_decode_err  <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            case (r_state)
                ST_SETTLE: begin
                    if (w_capture) begin
                        r_state <= ST_HOLD;
                        if (!w_digit1) begin
                            r_d0      <= w_dec[NIB_W-1:0];
                            r_err0    <= w_dec[NIB_W];
                            r_have_d0 <= 1'b1;
                        end else if (r_have_d0) begin
                            r_value       <= {w_dec[NIB_W-1:0], r_d0};
                            r_decode_err  <= r_err0 | w_dec[NIB_W];
                            r_frame_valid <= 1'b1;
                            r_have_d0     <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_cath_toggle) begin
                        r_state <= ST_SETTLE;
                    end
                end
                default: r_state <= ST_SETTLE;
            endcase
        end
    end

`ifdef SEV_SEG_CAPTURE_RAW_EN
    logic [SEG_W-1:0] r_raw_d0;
    logic [SEG_W-1:0] r_raw_digit_0;
    logic [SEG_W-1:0] r_raw_digit_1;

    // Raw lit patterns, tracking the same captures as the decoded frame.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_raw_d0      <= '0;
            r_raw_digit_0 <= '0;
            r_raw_digit_1 <= '0;
        end else if (w_capture) begin
            if (!w_digit1) begin
                r_raw_d0 <= w_seg;
            end else if (r_have_d0) begin
                r_raw_digit_0 <= r_raw_d0;
                r_raw_digit_1 <= w_seg;
            end
        end
    end

    assign o_raw_digit_0 = r_raw_digit_0;
    assign o_raw_digit_1 = r_raw_digit_1;
`endif

    assign o_value       = r_value;
    assign o_frame_valid = r_frame_valid;
    assign o_decode_err  = r_decode_err;
    assign o_stale       = r_stale;

endmodule
